// File: rtl/lfsr_hexdisp_if.sv
// Bundles the control inputs and display/status outputs of lfsr_hexdisp.
// The master side drives en/step/load/seed and observes the rest.
interface lfsr_hexdisp_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned NDIG = WIDTH / 4;

    logic                  en;
    logic                  step;
    logic                  load;
    logic [WIDTH-1:0]      seed;
    logic [WIDTH-1:0]      q;
    logic                  wrap;
    logic [WIDTH-1:0]      period;
    logic [8*NDIG-1:0]     seg;

    modport master (
        output en, step, load, seed,
        input  q, wrap, period, seg
    );

    modport slave (
        input  en, step, load, seed,
        output q, wrap, period, seg
    );
endinterface

// File: rtl/lfsr_hexdisp.sv
// Fibonacci LFSR with seed load, zero-lock protection, free-run/single-step,
// period detection and a registered active-low hex seven-segment driver.
// WIDTH must be a multiple of 4 in 4..32; RESET_SEED must be nonzero.
module lfsr_hexdisp #(
    parameter int unsigned      WIDTH      = 8,
    parameter logic [WIDTH-1:0] TAPS       = WIDTH'(8'h1D),
    parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(1)
) (
    input logic             clk,
    input logic             rst,
    lfsr_hexdisp_if.slave   bus
);
    localparam int unsigned NDIG = WIDTH / 4;

    logic [WIDTH-1:0]  q_q, q_d;
    logic [WIDTH-1:0]  seed_q, seed_d;
    logic [WIDTH-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  period_q, period_d;
    logic              wrap_q, wrap_d;
    logic [8*NDIG-1:0] seg_q, seg_d;
    logic [WIDTH-1:0]  q_step;
    logic [WIDTH-1:0]  seed_safe;

    // Active-high glyphs, segment a in bit 7 down to g in bit 1; dp (bit 0) stays 0.
    function automatic logic [7:0] glyph(input logic [3:0] nib);
        logic [7:0] g;
        case (nib)
            4'h0:    g = 8'hFC;
            4'h1:    g = 8'h60;
            4'h2:    g = 8'hDA;
            4'h3:    g = 8'hF2;
            4'h4:    g = 8'h66;
            4'h5:    g = 8'hB6;
            4'h6:    g = 8'hBE;
            4'h7:    g = 8'hE0;
            4'h8:    g = 8'hFE;
            4'h9:    g = 8'hF6;
            4'hA:    g = 8'hEE;
            4'hB:    g = 8'h3E;
            4'hC:    g = 8'h9C;
            4'hD:    g = 8'h7A;
            4'hE:    g = 8'h9E;
            default: g = 8'h8E;
        endcase
        return g;
    endfunction

    // Next LFSR state and load/step/hold priority with period tracking.
    always_comb begin
        q_d       = q_q;
        seed_d    = seed_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        wrap_d    = 1'b0;
        // A zero state would lock the LFSR, so a step out of it restarts at 1.
        q_step    = (q_q == '0) ? WIDTH'(1) : {^(q_q & TAPS), q_q[WIDTH-1:1]};
        seed_safe = (bus.seed == '0) ? WIDTH'(1) : bus.seed;

        if (bus.load) begin
            q_d    = seed_safe;
            seed_d = seed_safe;
            cnt_d  = '0;
        end else if (bus.en || bus.step) begin
            q_d = q_step;
            if (q_step == seed_q) begin
                wrap_d   = 1'b1;
                period_d = cnt_q + 1'b1;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Segment pattern for the current q; dp comes out as 1 after inversion.
    always_comb begin
        seg_d = '1;
        for (int i = 0; i < int'(NDIG); i++) begin
            seg_d[8*i +: 8] = ~glyph(q_q[4*i +: 4]);
        end
    end

    // State registers with synchronous reset; display blanks during reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q      <= RESET_SEED;
            seed_q   <= RESET_SEED;
            cnt_q    <= '0;
            period_q <= '0;
            wrap_q   <= 1'b0;
            seg_q    <= '1;
        end else begin
            q_q      <= q_d;
            seed_q   <= seed_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            wrap_q   <= wrap_d;
            seg_q    <= seg_d;
        end
    end

    assign bus.q      = q_q;
    assign bus.wrap   = wrap_q;
    assign bus.period = period_q;
    assign bus.seg    = seg_q;
endmodule

// File: tb/tb_lfsr_hexdisp.sv
// Directed bench for lfsr_hexdisp: an 8-bit instance (TAPS 1D) and a 4-bit
// instance (TAPS 3) share clock and reset; expected values are hand-derived.
module tb_lfsr_hexdisp;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_miss;

    lfsr_hexdisp_if #(.WIDTH(8)) if8 ();
    lfsr_hexdisp_if #(.WIDTH(4)) if4 ();

    lfsr_hexdisp #(
        .WIDTH      (8),
        .TAPS       (8'h1D),
        .RESET_SEED (8'h01)
    ) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8)
    );

    lfsr_hexdisp #(
        .WIDTH      (4),
        .TAPS       (4'h3),
        .RESET_SEED (4'h1)
    ) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4)
    );

    // Active-low segment bytes (dp off) for nibbles 0..F, inverted by hand.
    logic [7:0] seg_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
    // 8-bit free-run sequence from 01 with TAPS 1D.
    logic [7:0] seq8 [7] = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h88, 8'hC4};
    // 4-bit maximal sequence from 1 with TAPS 3 (period 15).
    logic [3:0] seq4 [15] = '{4'h1, 4'h8, 4'h4, 4'h2, 4'h9, 4'hC, 4'h6, 4'hB,
                              4'h5, 4'hA, 4'hD, 4'hE, 4'hF, 4'h7, 4'h3};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        tick();
        n_vec++;
        if (if8.q !== 8'h01) begin
            n_miss++; $display("FAIL reset_q8: got %h expected %h", if8.q, 8'h01);
        end
        n_vec++;
        if (if8.seg !== 16'hFFFF) begin
            n_miss++; $display("FAIL reset_seg8: got %h expected %h", if8.seg, 16'hFFFF);
        end
        n_vec++;
        if (if8.wrap !== 1'b0 || if8.period !== 8'h00) begin
            n_miss++;
            $display("FAIL reset_wrap_period8: got %b/%h expected 0/00", if8.wrap, if8.period);
        end
        n_vec++;
        if (if4.q !== 4'h1) begin
            n_miss++; $display("FAIL reset_q4: got %h expected %h", if4.q, 4'h1);
        end
    endtask

    task automatic test_free_run();
        @(negedge clk);
        rst    = 1'b0;
        if8.en = 1'b1;
        for (int k = 1; k < 7; k++) begin
            tick();
            n_vec++;
            if (if8.q !== seq8[k]) begin
                n_miss++; $display("FAIL free_run_q[%0d]: got %h expected %h", k, if8.q, seq8[k]);
            end
            n_vec++;
            if (if8.seg !== {seg_tab[seq8[k-1][7:4]], seg_tab[seq8[k-1][3:0]]}) begin
                n_miss++;
                $display("FAIL free_run_seg[%0d]: got %h expected %h", k, if8.seg,
                         {seg_tab[seq8[k-1][7:4]], seg_tab[seq8[k-1][3:0]]});
            end
            n_vec++;
            if (if8.wrap !== 1'b0) begin
                n_miss++; $display("FAIL free_run_wrap[%0d]: got %b expected 0", k, if8.wrap);
            end
        end
        @(negedge clk);
        if8.en = 1'b0;
    endtask

    task automatic test_load();
        @(negedge clk);
        if8.load = 1'b1;
        if8.seed = 8'h00;
        tick();
        n_vec++;
        if (if8.q !== 8'h01) begin
            n_miss++; $display("FAIL load_zero_q: got %h expected %h", if8.q, 8'h01);
        end
        @(negedge clk);
        if8.seed = 8'hA5;
        if8.en   = 1'b1;
        tick();
        n_vec++;
        if (if8.q !== 8'hA5) begin
            n_miss++; $display("FAIL load_over_en_q: got %h expected %h", if8.q, 8'hA5);
        end
        n_vec++;
        if (if8.wrap !== 1'b0) begin
            n_miss++; $display("FAIL load_wrap: got %b expected 0", if8.wrap);
        end
        @(negedge clk);
        if8.load = 1'b0;
        if8.en   = 1'b0;
        tick();
        n_vec++;
        if (if8.q !== 8'hA5 || if8.seg !== 16'h1149) begin
            n_miss++;
            $display("FAIL load_hold: got q=%h seg=%h expected q=a5 seg=1149", if8.q, if8.seg);
        end
    endtask

    task automatic test_step();
        logic [7:0] exp_q [6] = '{8'h52, 8'h52, 8'h52, 8'hA9, 8'h54, 8'h54};
        logic       stp   [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if8.step = stp[k];
            tick();
            n_vec++;
            if (if8.q !== exp_q[k]) begin
                n_miss++; $display("FAIL step_q[%0d]: got %h expected %h", k, if8.q, exp_q[k]);
            end
        end
        @(negedge clk);
        if8.step = 1'b0;
    endtask

    task automatic test_full_cycle();
        @(negedge clk);
        if4.load = 1'b1;
        if4.seed = 4'h1;
        tick();
        n_vec++;
        if (if4.q !== 4'h1 || if4.wrap !== 1'b0) begin
            n_miss++; $display("FAIL cycle_load: got q=%h wrap=%b expected 1/0", if4.q, if4.wrap);
        end
        @(negedge clk);
        if4.load = 1'b0;
        if4.en   = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            n_vec++;
            if (if4.q !== seq4[k % 15]) begin
                n_miss++; $display("FAIL cycle_q[%0d]: got %h expected %h", k, if4.q, seq4[k % 15]);
            end
            n_vec++;
            if (if4.wrap !== (k % 15 == 0)) begin
                n_miss++;
                $display("FAIL cycle_wrap[%0d]: got %b expected %b", k, if4.wrap, (k % 15 == 0));
            end
            if (k == 14) begin
                n_vec++;
                if (if4.period !== 4'h0) begin
                    n_miss++; $display("FAIL cycle_period_pre: got %h expected 0", if4.period);
                end
            end
            if (k == 15 || k == 30) begin
                n_vec++;
                if (if4.period !== 4'hF) begin
                    n_miss++; $display("FAIL cycle_period[%0d]: got %h expected f", k, if4.period);
                end
            end
        end
    endtask

    task automatic test_glyphs();
        logic [7:0] s;
        for (int i = 0; i < 16; i++) begin
            s = {4'(i), 4'(15 - i)};
            @(negedge clk);
            if8.load = 1'b1;
            if8.seed = s;
            tick();
            n_vec++;
            if (if8.q !== s) begin
                n_miss++; $display("FAIL glyph_load[%0d]: got %h expected %h", i, if8.q, s);
            end
            @(negedge clk);
            if8.load = 1'b0;
            tick();
            n_vec++;
            if (if8.seg !== {seg_tab[i], seg_tab[15 - i]}) begin
                n_miss++;
                $display("FAIL glyph_seg[%0d]: got %h expected %h", i, if8.seg,
                         {seg_tab[i], seg_tab[15 - i]});
            end
        end
    endtask

    task automatic test_reset_midrun();
        @(negedge clk);
        if8.en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst      = 1'b1;
        if8.load = 1'b1;
        if8.seed = 8'hA5;
        tick();
        n_vec++;
        if (if8.q !== 8'h01 || if8.wrap !== 1'b0 || if8.period !== 8'h00) begin
            n_miss++;
            $display("FAIL midrun_state8: got q=%h wrap=%b period=%h expected 01/0/00",
                     if8.q, if8.wrap, if8.period);
        end
        n_vec++;
        if (if8.seg !== 16'hFFFF) begin
            n_miss++; $display("FAIL midrun_seg8: got %h expected ffff", if8.seg);
        end
        n_vec++;
        if (if4.q !== 4'h1 || if4.period !== 4'h0 || if4.seg !== 8'hFF) begin
            n_miss++;
            $display("FAIL midrun_state4: got q=%h period=%h seg=%h expected 1/0/ff",
                     if4.q, if4.period, if4.seg);
        end
        @(negedge clk);
        rst      = 1'b0;
        if8.load = 1'b0;
        if8.en   = 1'b0;
        tick();
        n_vec++;
        if (if8.q !== 8'h01 || if8.seg !== 16'h039F) begin
            n_miss++;
            $display("FAIL midrun_release8: got q=%h seg=%h expected 01/039f", if8.q, if8.seg);
        end
        // The 4-bit instance kept en high; its counter must restart at zero.
        for (int k = 1; k <= 15; k++) begin
            if (k > 1) tick();
            n_vec++;
            if (if4.wrap !== (k == 15)) begin
                n_miss++;
                $display("FAIL midrun_restart_wrap[%0d]: got %b expected %b", k, if4.wrap, (k == 15));
            end
        end
        n_vec++;
        if (if4.period !== 4'hF) begin
            n_miss++; $display("FAIL midrun_restart_period: got %h expected f", if4.period);
        end
    endtask

    initial begin
        n_vec    = 0;
        n_miss   = 0;
        rst      = 1'b1;
        if8.en   = 1'b0;
        if8.step = 1'b0;
        if8.load = 1'b0;
        if8.seed = '0;
        if4.en   = 1'b0;
        if4.step = 1'b0;
        if4.load = 1'b0;
        if4.seed = '0;

        test_reset();
        test_free_run();
        test_load();
        test_step();
        test_full_cycle();
        test_glyphs();
        test_reset_midrun();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/lfsr_hexdisp.md
# lfsr_hexdisp

Parametrised Fibonacci LFSR with a registered multi-digit hex seven-segment driver, the next generation of our 8-bit LFSR demo block. It adds configurable width and tap mask, seed loading with zero-lock protection, free-run and single-step modes, and period detection. The full 0–F glyph set drives one active-low digit per nibble. It sits between board I/O (switches and buttons) and the seven-segment display pins.

## Interface
- WIDTH, 8: LFSR width in bits. Must be a multiple of 4, range 4..32.
- TAPS, 8'h1D: feedback mask over q bits; new bit = XOR-reduce(q & TAPS).
- RESET_SEED, 1: q value after reset. Must be nonzero.
- NDIG, WIDTH/4: digit count; derived, not overridable.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  free-run: advance one step every cycle while high.
- step  in  1  single step: advance one step in any cycle where it is high (OR-ed with en).
- load  in  1  load seed this cycle.
- seed  in  WIDTH  seed value for load.
- q  out  WIDTH  LFSR state (registered).
- wrap  out  1  one-cycle pulse: q just returned to the stored seed.
- period  out  WIDTH  step count of the last completed cycle (registered).
- seg  out  8*NDIG  active-low segments; byte i (seg[8i+7:8i]) shows q[4i+3:4i]; bit 7=a … bit 1=g, bit 0=dp.

## Operation
- Step: q <= {fb, q[WIDTH-1:1]}, where fb = ^(q & TAPS). The shift is right and fb enters the MSB.
- Priority per cycle: rst > load > (en|step) > hold.
- Load: q <= seed, and seed_reg <= seed. If seed == 0, both take 1 instead (zero-lock protection). Load clears the step counter and does not pulse wrap.
- Reset: q = RESET_SEED, seed_reg = RESET_SEED, step counter = 0, period = 0, wrap = 0, seg = all ones (blank).
- Step counter (internal, WIDTH bits):
  - Increments on each step.
  - When a step produces next-q == seed_reg: wrap <= 1, period <= counter+1 (truncated to WIDTH), counter <= 0.
  - Otherwise wrap <= 0.
- Hold (no load, no step): q, counter and period unchanged; wrap <= 0.
- If q is somehow zero (only possible with a bad TAPS/seed combination), a step forces q <= 1.
- Glyphs are active-high before inversion; seg = ~glyph, and dp is always off (bit 0 = 1 at the output). Glyph values:
  - 0=FC 1=60 2=DA 3=F2 4=66 5=B6 6=BE 7=E0
  - 8=FE 9=F6 A=EE b=3E C=9C d=7A E=9E F=8E
- seg is registered from the current q. It therefore shows the q of the previous cycle.

## Timing
- q, wrap and period update on the clock edge after the qualifying inputs. Latency is 1 cycle.
- seg lags q by exactly 1 cycle. After reset release, the first valid seg appears one edge later (glyphs of RESET_SEED).
- wrap is high for exactly one cycle, in the same cycle the returned-to-seed q is visible. Back-to-back wraps are only possible for period 1.
- load with en/step high: load wins and no step occurs that cycle.
- rst with load high: reset wins and seed is ignored.
- Reset mid-run: all state returns to reset values on that edge, and the counter restarts at 0.
- period saturation: none; the counter wraps modulo 2^WIDTH. For a maximal-length LFSR the period is 2^WIDTH−1, which fits.

## Test plan
- Reset then en=1, WIDTH=8, TAPS=1D: q sequence 01, 80, 40, 20, 10, 88, C4. seg lags q by one cycle, and seg for q=01 reads {~FC, ~60} = {03, 9F}.
- load=1, seed=0: q=01 next cycle and seed_reg=01. With load=1, seed=A5 and en=1 in the same cycle: q=A5 and no step.
- step pulses with en=0: exactly one advance per high cycle of step, and q holds between pulses. Two consecutive step cycles give two advances.
- Full cycle, WIDTH=4, TAPS=3, seed=1, en=1: wrap pulses every 15 steps, period=15, counter restarts. The first wrap arrives 15 cycles after load.
- All 16 glyphs: load seeds 0x0F..0xF0 (covering each nibble value in both digits) with en=0. seg matches ~glyph table with dp bit = 1.
- rst asserted mid-run with load high: the next cycle has q=RESET_SEED, wrap=0, period=0, seg=all ones.
